pipe_ctrl: RTL and testbench

Pipeline control unit for the 16-bit core. It produces the enable and flush strobes consumed by the IF/ID and ID/EX pipeline registers and the PC enable. It detects load-use hazards, taken branches, halt and memory-busy conditions, and runs a small state machine for reset-flush, halt-drain and halted states. It sits beside the ID and EX stages and drives the `en_*` and `flush_*` inputs of the stage registers.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_hazard_detect.sv | 19 +
 rtl/pipe_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control unit: FSM state encoding and the
// strobe bundle driven onto the stage registers and PC.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {INIT, RUN, DRAIN, HALTED} pipe_state_t;

  typedef struct packed {
    logic pc_en;
    logic en_ifid;
    logic en_idex;
    logic flush_ifid;
    logic flush_idex;
  } pipe_strobe_t;

  localparam pipe_strobe_t STB_FREEZE    = '0;
  localparam pipe_strobe_t STB_FLUSH_ALL = 5'b01111;
  localparam pipe_strobe_t STB_RUN       = 5'b11100;
  localparam pipe_strobe_t STB_BRANCH    = 5'b11111;
  localparam pipe_strobe_t STB_STALL     = 5'b00101;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: the EX load targets a register the ID instruction reads.
module hazard_detect (
  input  logic [2:0] ra_id,
  input  logic [2:0] rb_id,
  input  logic       ra_used_id,
  input  logic       rb_used_id,
  input  logic [2:0] regwrite_adr_ex,
  input  logic       regwrite_ex,
  input  logic       from_main_mem_ex,
  output logic       load_use
);

  always_comb begin
    load_use = from_main_mem_ex & regwrite_ex &
               ((ra_used_id & (ra_id == regwrite_adr_ex)) |
                (rb_used_id & (rb_id == regwrite_adr_ex)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: combinational stage strobes plus the INIT/RUN/DRAIN/HALTED
// state machine, halt drain counter and saturating load-use stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ra_id,
  input  logic [2:0]       rb_id,
  input  logic             ra_used_id,
  input  logic             rb_used_id,
  input  logic [2:0]       regwrite_adr_ex,
  input  logic             regwrite_ex,
  input  logic             from_main_mem_ex,
  input  logic             branch_taken_ex,
  input  logic             is_halt_ex,
  input  logic             mem_busy,
  input  logic             resume,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  pipe_state_t  state;
  logic [2:0]   drain_cnt;
  logic         resume_q;
  logic         resume_pulse;
  logic         load_use;
  pipe_strobe_t stb;

  hazard_detect u_hazard (
    .ra_id            (ra_id),
    .rb_id            (rb_id),
    .ra_used_id       (ra_used_id),
    .rb_used_id       (rb_used_id),
    .regwrite_adr_ex  (regwrite_adr_ex),
    .regwrite_ex      (regwrite_ex),
    .from_main_mem_ex (from_main_mem_ex),
    .load_use         (load_use)
  );

  // A held resume level only counts once, on its rising edge.
  assign resume_pulse = resume & ~resume_q;

  always_comb begin
    stb = STB_FREEZE;
    unique case (state)
      INIT:   stb = STB_FLUSH_ALL;
      RUN: begin
        if (mem_busy)             stb = STB_FREEZE;
        else if (is_halt_ex)      stb = STB_FLUSH_ALL;
        else if (branch_taken_ex) stb = STB_BRANCH;
        else if (load_use)        stb = STB_STALL;
        else                      stb = STB_RUN;
      end
      DRAIN:  stb = mem_busy ? STB_FREEZE : STB_FLUSH_ALL;
      HALTED: stb = STB_FREEZE;
      default: stb = STB_FREEZE;
    endcase
  end

  assign pc_en      = stb.pc_en;
  assign en_ifid    = stb.en_ifid;
  assign en_idex    = stb.en_idex;
  assign flush_ifid = stb.flush_ifid;
  assign flush_idex = stb.flush_idex;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      drain_cnt   <= '0;
      resume_q    <= 1'b0;
      halted      <= 1'b0;
      stall_count <= '0;
    end else begin
      resume_q <= resume;
      unique case (state)
        INIT: state <= RUN;
        RUN: begin
          if (!mem_busy) begin
            if (is_halt_ex) begin
              state     <= DRAIN;
              drain_cnt <= 3'(DRAIN_CYCLES - 1);
            end else if (!branch_taken_ex && load_use && (stall_count != '1)) begin
              stall_count <= stall_count + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!mem_busy) begin
            if (drain_cnt == '0) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 3'd1;
            end
          end
        end
        HALTED: begin
          if (resume_pulse) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: RUN-priority vector table plus hand-written
// halt/drain/resume, saturation and asynchronous-reset sequences.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ra_id, rb_id, regwrite_adr_ex;
  logic       ra_used_id, rb_used_id, regwrite_ex, from_main_mem_ex;
  logic       branch_taken_ex, is_halt_ex, mem_busy, resume;
  logic       pc_en, en_ifid, en_idex, flush_ifid, flush_idex, halted;
  logic [3:0] stall_count;

  pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .ra_id            (ra_id),
    .rb_id            (rb_id),
    .ra_used_id       (ra_used_id),
    .rb_used_id       (rb_used_id),
    .regwrite_adr_ex  (regwrite_adr_ex),
    .regwrite_ex      (regwrite_ex),
    .from_main_mem_ex (from_main_mem_ex),
    .branch_taken_ex  (branch_taken_ex),
    .is_halt_ex       (is_halt_ex),
    .mem_busy         (mem_busy),
    .resume           (resume),
    .pc_en            (pc_en),
    .en_ifid          (en_ifid),
    .en_idex          (en_idex),
    .flush_ifid       (flush_ifid),
    .flush_idex       (flush_idex),
    .halted           (halted),
    .stall_count      (stall_count)
  );

  always #5 clk = ~clk;

  // Strobe order: {pc_en, en_ifid, en_idex, flush_ifid, flush_idex}
  localparam logic [4:0] S_FL  = 5'b01111;
  localparam logic [4:0] S_RUN = 5'b11100;
  localparam logic [4:0] S_BR  = 5'b11111;
  localparam logic [4:0] S_ST  = 5'b00101;
  localparam logic [4:0] S_FZ  = 5'b00000;

  typedef struct packed {
    logic [2:0] ra;
    logic [2:0] rb;
    logic       ra_u;
    logic       rb_u;
    logic [2:0] adr;
    logic       rw;
    logic       ld;
    logic       br;
    logic       halt;
    logic       busy;
    logic       res;
  } in_t;

  typedef struct {
    string      name;
    logic [4:0] stb;
    logic       h;
    logic [3:0] cnt;
  } exp_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [4:0] stb;
    logic [3:0] cnt;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic in_t inp(logic [2:0] ra, logic [2:0] rb, logic ra_u, logic rb_u,
                              logic [2:0] adr, logic rw, logic ld, logic br,
                              logic halt, logic busy, logic res);
    in_t i;
    i.ra = ra; i.rb = rb; i.ra_u = ra_u; i.rb_u = rb_u; i.adr = adr;
    i.rw = rw; i.ld = ld; i.br = br; i.halt = halt; i.busy = busy; i.res = res;
    return i;
  endfunction

  function automatic vec_t mkv(string name, in_t i, logic [4:0] stb, logic [3:0] cnt);
    vec_t v;
    v.name = name; v.in = i; v.stb = stb; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input in_t i);
    ra_id = i.ra; rb_id = i.rb; ra_used_id = i.ra_u; rb_used_id = i.rb_u;
    regwrite_adr_ex = i.adr; regwrite_ex = i.rw; from_main_mem_ex = i.ld;
    branch_taken_ex = i.br; is_halt_ex = i.halt; mem_busy = i.busy; resume = i.res;
  endtask

  task automatic expect_push(input string name, input logic [4:0] stb,
                             input logic h, input logic [3:0] cnt);
    exp_t e;
    e.name = name; e.stb = stb; e.h = h; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [4:0] act;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    act = {pc_en, en_ifid, en_idex, flush_ifid, flush_idex};
    if (act !== e.stb || halted !== e.h || stall_count !== e.cnt) begin
      n_fail++;
      $display("FAIL %s: got strobes=%b halted=%b stall_count=%0d, want strobes=%b halted=%b stall_count=%0d",
               e.name, act, halted, stall_count, e.stb, e.h, e.cnt);
    end
  endtask

  // Drive one cycle's inputs just after a rising edge, check at the falling edge.
  task automatic step(input string name, input in_t i, input logic [4:0] stb,
                      input logic h, input logic [3:0] cnt);
    drive(i);
    expect_push(name, stb, h, cnt);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  in_t idle, lu, halt_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle    = inp(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lu      = inp(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    halt_in = inp(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    //                      ra    rb    rau   rbu   adr   rw    ld    br    halt  busy  res
    tbl.push_back(mkv("idle",        idle,                                                          S_RUN, 4'd0));
    tbl.push_back(mkv("lu_ra",       lu,                                                            S_ST,  4'd0));
    tbl.push_back(mkv("ra_unused",   inp(3'd3, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), S_RUN, 4'd1));
    tbl.push_back(mkv("lu_rb",       inp(3'd1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), S_ST,  4'd1));
    tbl.push_back(mkv("not_load",    inp(3'd1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), S_RUN, 4'd2));
    tbl.push_back(mkv("no_regwrite", inp(3'd5, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), S_RUN, 4'd2));
    tbl.push_back(mkv("reg0_lu",     inp(3'd0, 3'd4, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), S_ST,  4'd2));
    tbl.push_back(mkv("adr_mismatch",inp(3'd2, 3'd4, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), S_RUN, 4'd3));
    tbl.push_back(mkv("branch",      inp(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), S_BR,  4'd3));
    tbl.push_back(mkv("branch_lu",   inp(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), S_BR,  4'd3));
    tbl.push_back(mkv("busy_lu",     inp(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), S_FZ,  4'd3));
    tbl.push_back(mkv("after_busy",  idle,                                                          S_RUN, 4'd3));
    tbl.push_back(mkv("busy_halt",   inp(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), S_FZ,  4'd3));
    tbl.push_back(mkv("still_run",   idle,                                                          S_RUN, 4'd3));

    // Reset held for three cycles, then exactly one INIT cycle.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("in_reset", idle, S_FL, 1'b0, 4'd0);
    reset = 1'b1;
    step("init_cycle", idle, S_FL, 1'b0, 4'd0);

    foreach (tbl[k]) step(tbl[k].name, tbl[k].in, tbl[k].stb, 1'b0, tbl[k].cnt);

    // Halt beats a simultaneous branch; one busy cycle stretches the drain.
    step("halt_and_branch", inp(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), S_FL, 1'b0, 4'd3);
    step("drain_busy",      inp(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), S_FZ, 1'b0, 4'd3);
    step("drain_1_lu",      lu,   S_FL, 1'b0, 4'd3);
    step("drain_2",         idle, S_FL, 1'b0, 4'd3);
    step("drain_3",         idle, S_FL, 1'b0, 4'd3);
    step("halted_ignores",  inp(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), S_FZ, 1'b1, 4'd3);
    step("resume_pulse",    inp(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), S_FZ, 1'b1, 4'd3);
    step("resumed_run",     inp(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), S_RUN, 1'b0, 4'd3);
    step("resume_held",     inp(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), S_RUN, 1'b0, 4'd3);
    step("run_idle",        idle, S_RUN, 1'b0, 4'd3);

    // Saturate the 4-bit stall counter.
    for (int i = 0; i < 14; i++)
      step("saturate", lu, S_ST, 1'b0, (3 + i > 15) ? 4'd15 : 4'(3 + i));
    step("sat_hold", idle, S_RUN, 1'b0, 4'd15);

    // Asynchronous reset in the middle of a drain.
    step("halt_again", halt_in, S_FL, 1'b0, 4'd15);
    step("drain_a",    idle,    S_FL, 1'b0, 4'd15);
    reset = 1'b0;
    expect_push("reset_mid_drain", S_FL, 1'b0, 4'd0);
    #1;
    check_out();
    @(posedge clk);
    #1;
    step("reset_hold", idle, S_FL, 1'b0, 4'd0);
    reset = 1'b1;
    step("init_again", idle, S_FL, 1'b0, 4'd0);

    // Asynchronous reset while halted.
    step("halt_b",   halt_in, S_FL, 1'b0, 4'd0);
    step("drain_b1", idle,    S_FL, 1'b0, 4'd0);
    step("drain_b2", idle,    S_FL, 1'b0, 4'd0);
    step("drain_b3", idle,    S_FL, 1'b0, 4'd0);
    step("halted_b", idle,    S_FZ, 1'b1, 4'd0);
    reset = 1'b0;
    expect_push("reset_in_halted", S_FL, 1'b0, 4'd0);
    #1;
    check_out();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("init_b", idle, S_FL,  1'b0, 4'd0);
    step("run_b",  idle, S_RUN, 1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
